// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared types for the tartaruga core.
// Holds the store buffer sizing, its index type, the entry record and the
// wrap-bit pointer used for circular head/commit/tail bookkeeping.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  localparam int STORE_BUFFER_SIZE = 4;
  localparam int SB_IDX_W          = $clog2(STORE_BUFFER_SIZE);

  typedef logic [SB_IDX_W-1:0] store_buffer_idx_t;

  // One buffered store: word address, lane-aligned data and byte enables.
  typedef struct packed {
    bus32_t     addr;
    bus32_t     data;
    logic [3:0] be;
  } sb_entry_t;

  // Circular pointer: the extra wrap bit distinguishes full from empty.
  typedef struct packed {
    logic              wrap;
    store_buffer_idx_t idx;
  } sb_ptr_t;

  localparam bus32_t SB_WORD_MASK = 32'hFFFF_FFFC;

  // Two byte addresses fall in the same aligned 32-bit word.
  function automatic logic same_word(input bus32_t a, input bus32_t b);
    return ((a ^ b) & SB_WORD_MASK) == '0;
  endfunction

endpackage

// File: rtl/sb_fwd_search.sv
// sb_fwd_search: combinational youngest-match search over the store buffer.
// Looks at the live entries [head, tail) and reports whether the youngest
// store to the load's word fully covers it (hit) or only partly (stall).
module sb_fwd_search
  import tartaruga_pkg::*;
#(
  parameter  int SB_SIZE = STORE_BUFFER_SIZE,
  localparam int IDX_W   = $clog2(SB_SIZE)
) (
  input  sb_entry_t      entries_i [SB_SIZE],
  input  logic [IDX_W:0] head_i,
  input  logic [IDX_W:0] tail_i,
  input  bus32_t         ld_addr_i,
  output logic           hit_o,
  output logic           stall_o,
  output bus32_t         data_o
);

  logic [IDX_W:0] occupancy;
  assign occupancy = tail_i - head_i;

  // Walk oldest to youngest so a younger match overrides any older one.
  always_comb begin
    logic [IDX_W-1:0] slot;
    // NOTE: every variable written here gets a default before any branch,
    // otherwise paths that skip an assignment would infer a latch.
    hit_o   = 1'b0;
    stall_o = 1'b0;
    data_o  = '0;
    slot    = '0;
    for (int k = 0; k < SB_SIZE; k++) begin
      slot = head_i[IDX_W-1:0] + IDX_W'(k);
      if (((IDX_W+1)'(k) < occupancy) && same_word(entries_i[slot].addr, ld_addr_i)) begin
        if (entries_i[slot].be == 4'hF) begin
          hit_o   = 1'b1;
          stall_o = 1'b0;
          data_o  = entries_i[slot].data;
        end else begin
          hit_o   = 1'b0;
          stall_o = 1'b1;
          data_o  = '0;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular buffer of stores between MEM and data memory.
// [head, cptr) holds committed stores waiting to drain in order;
// [cptr, tail) holds speculative stores that a flush may discard.
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter  int SB_SIZE = STORE_BUFFER_SIZE,
  localparam int IDX_W   = $clog2(SB_SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // allocation from MEM
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  bus32_t           alloc_addr_i,
  input  bus32_t           alloc_data_i,
  input  logic [3:0]       alloc_be_i,
  output logic [IDX_W-1:0] alloc_idx_o,
  // commit from the ROB
  input  logic             commit_valid_i,
  input  logic [IDX_W-1:0] commit_idx_i,
  input  logic             flush_i,
  // drain to data memory
  output logic             dmem_req_valid_o,
  input  logic             dmem_req_ready_i,
  output bus32_t           dmem_addr_o,
  output bus32_t           dmem_data_o,
  output logic [3:0]       dmem_be_o,
  // load forwarding
  input  bus32_t           ld_addr_i,
  output logic             fwd_hit_o,
  output bus32_t           fwd_data_o,
  output logic             fwd_stall_o,
  output logic             empty_o
);

  typedef logic [IDX_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t      head_q, head_d;
  ptr_t      cptr_q, cptr_d;
  ptr_t      tail_q, tail_d;
  sb_entry_t entries_q [SB_SIZE];
  sb_entry_t head_entry;

  logic full;
  logic alloc_fire;
  logic commit_fire;
  logic drain_fire;

  assign full    = (tail_q - head_q) == ptr_t'(SB_SIZE);
  assign empty_o = (tail_q == head_q);

  // Allocation never bypasses a same-cycle drain: readiness uses registered pointers only.
  assign alloc_ready_o = !full;
  assign alloc_idx_o   = tail_q[IDX_W-1:0];
  assign alloc_fire    = alloc_valid_i && !full && !flush_i;

  // Commits must name the oldest uncommitted entry; anything else is ignored.
  assign commit_fire = commit_valid_i && (cptr_q != tail_q) &&
                       (commit_idx_i == cptr_q[IDX_W-1:0]);

  // The oldest committed store drives the memory request directly.
  assign head_entry       = entries_q[head_q[IDX_W-1:0]];
  assign dmem_req_valid_o = (head_q != cptr_q);
  assign dmem_addr_o      = head_entry.addr;
  assign dmem_data_o      = head_entry.data;
  assign dmem_be_o        = head_entry.be;
  assign drain_fire       = dmem_req_valid_o && dmem_req_ready_i;

  // Pointer next state: a same-cycle commit is applied before the flush so it survives.
  always_comb begin
    head_d = head_q;
    cptr_d = cptr_q;
    tail_d = tail_q;
    if (drain_fire)  head_d = head_q + PTR_ONE;
    if (commit_fire) cptr_d = cptr_q + PTR_ONE;
    if (flush_i) begin
      tail_d = cptr_d;
    end else if (alloc_fire) begin
      tail_d = tail_q + PTR_ONE;
    end
  end

  // Pointer registers with synchronous reset; a pending drain request simply vanishes.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      head_q <= '0;
      cptr_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cptr_q <= cptr_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage written at tail on each accepted allocation.
  always_ff @(posedge clk_i) begin
    // NOTE: the entry array has no reset; pointers alone decide which slots are
    // live, so resetting the data would only cost flops and routing.
    if (alloc_fire) begin
      entries_q[tail_q[IDX_W-1:0]] <= '{addr: alloc_addr_i, data: alloc_data_i, be: alloc_be_i};
    end
  end

  sb_fwd_search #(
    .SB_SIZE (SB_SIZE)
  ) u_fwd_search (
    .entries_i (entries_q),
    .head_i    (head_q),
    .tail_i    (tail_q),
    .ld_addr_i (ld_addr_i),
    .hit_o     (fwd_hit_o),
    .stall_o   (fwd_stall_o),
    .data_o    (fwd_data_o)
  );

endmodule
